// File: rtl/dbus_stream_port.sv
// Data-bus responder bridging CPU loads/stores to a TX and an RX word stream.
// Each FIFO is a circular buffer; read data is zero unless this block is read.
module dbus_stream_port #(
  parameter logic [31:0] BASE_ADDR = 32'hFF20_0100,
  parameter int unsigned DEPTH     = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iDwReadEnable,
  input  logic        iDwWriteEnable,
  input  logic [3:0]  iDwByteEnable,
  input  logic [31:0] iDwAddress,
  input  logic [31:0] iDwWriteData,
  output logic [31:0] oDwReadData,
  output logic [31:0] oTxData,
  output logic        oTxValid,
  input  logic        iTxReady,
  input  logic [31:0] iRxData,
  input  logic        iRxValid,
  output logic        oRxReady,
  output logic        oIRQ
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   tx_mem [DEPTH];
  logic [31:0]   rx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic          tx_of_q, tx_of_d, rx_uf_q, rx_uf_d, irq_q;
  logic          prev_rd_q, prev_wr_q;
  logic [31:0]   prev_addr_q;

  logic       sel, rd_act, wr_act, ctrl_wr;
  logic [1:0] offset;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push_req, tx_push, tx_pop, tx_flush, tx_of_set;
  logic       rx_pop_req, rx_push, rx_pop, rx_flush, rx_uf_set, sticky_clr;
  logic [31:0] status;

  // An access acts only in its first cycle: enable newly raised or address moved.
  assign sel    = (iDwAddress[31:4] == BASE_ADDR[31:4]);
  assign offset = iDwAddress[3:2];
  assign wr_act = sel && iDwWriteEnable &&
                  !(prev_wr_q && (iDwAddress == prev_addr_q));
  assign rd_act = sel && iDwReadEnable && !iDwWriteEnable &&
                  !(prev_rd_q && (iDwAddress == prev_addr_q));

  assign ctrl_wr    = wr_act && (offset == 2'd2);
  assign tx_flush   = ctrl_wr && iDwWriteData[0];
  assign rx_flush   = ctrl_wr && iDwWriteData[1];
  assign sticky_clr = ctrl_wr && iDwWriteData[2];

  assign tx_full  = (tx_count_q == CW'(DEPTH));
  assign tx_empty = (tx_count_q == '0);
  assign rx_full  = (rx_count_q == CW'(DEPTH));
  assign rx_empty = (rx_count_q == '0);

  // Streams use valid/ready: a word moves on any rising edge where both are high;
  // valid never depends on ready, and ready only reflects local FIFO space.
  assign oTxValid = !tx_empty;
  assign oTxData  = tx_mem[tx_rd_ptr_q];
  assign oRxReady = iRST && !rx_full;
  assign oIRQ     = irq_q;

  assign tx_pop      = oTxValid && iTxReady;
  assign tx_push_req = wr_act && (offset == 2'd0) && (iDwByteEnable == 4'b1111);
  assign tx_push     = tx_push_req && (!tx_full || iTxReady);
  assign tx_of_set   = tx_push_req && tx_full && !iTxReady;

  assign rx_push    = iRxValid && oRxReady;
  assign rx_pop_req = rd_act && (offset == 2'd0);
  assign rx_pop     = rx_pop_req && !rx_empty;
  assign rx_uf_set  = rx_pop_req && rx_empty;

  assign status = {8'h00, 8'(rx_count_q), 8'(tx_count_q), 2'b00,
                   rx_uf_q, tx_of_q, rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    oDwReadData = '0;
    if (sel && iDwReadEnable) begin
      case (offset)
        2'd0:    oDwReadData = rx_empty ? '0 : rx_mem[rx_rd_ptr_q];
        2'd1:    oDwReadData = status;
        default: oDwReadData = '0;
      endcase
    end
  end

  // Flush overrides any concurrent push or pop on the same FIFO.
  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    if (tx_flush) begin
      tx_wr_ptr_d = '0;
      tx_rd_ptr_d = '0;
      tx_count_d  = '0;
    end else begin
      if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + 1'b1;
      if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
      if (tx_push && !tx_pop)      tx_count_d = tx_count_q + 1'b1;
      else if (!tx_push && tx_pop) tx_count_d = tx_count_q - 1'b1;
    end
  end

  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    if (rx_flush) begin
      rx_wr_ptr_d = '0;
      rx_rd_ptr_d = '0;
      rx_count_d  = '0;
    end else begin
      if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + 1'b1;
      if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
      if (rx_push && !rx_pop)      rx_count_d = rx_count_q + 1'b1;
      else if (!rx_push && rx_pop) rx_count_d = rx_count_q - 1'b1;
    end
  end

  // A new error event in the same cycle as a clear leaves the flag set.
  assign tx_of_d = tx_of_set || (tx_of_q && !sticky_clr);
  assign rx_uf_d = rx_uf_set || (rx_uf_q && !sticky_clr);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      tx_of_q     <= 1'b0;
      rx_uf_q     <= 1'b0;
      irq_q       <= 1'b0;
      prev_rd_q   <= 1'b0;
      prev_wr_q   <= 1'b0;
      prev_addr_q <= '0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      tx_of_q     <= tx_of_d;
      rx_uf_q     <= rx_uf_d;
      irq_q       <= !rx_empty;
      prev_rd_q   <= iDwReadEnable;
      prev_wr_q   <= iDwWriteEnable;
      prev_addr_q <= iDwAddress;
    end
  end

  // Storage is not reset; occupancy is tracked entirely by pointers and counts.
  always_ff @(posedge iCLK) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= iDwWriteData;
    if (rx_push) rx_mem[rx_wr_ptr_q] <= iRxData;
  end

endmodule

// File: tb/tb_dbus_stream_port.sv
// Randomised bench for dbus_stream_port: queue-based reference model of both
// FIFOs and the sticky flags, with a negedge monitor popping expected values.
module tb_dbus_stream_port;

  localparam int unsigned DEPTH  = 16;
  localparam logic [31:0] A_DATA = 32'hFF20_0100;
  localparam logic [31:0] A_STAT = 32'hFF20_0104;
  localparam logic [31:0] A_CTRL = 32'hFF20_0108;
  localparam logic [31:0] A_RSV  = 32'hFF20_010C;
  localparam logic [31:0] A_OTH  = 32'h1000_0000;

  logic        clk, rst_n;
  logic        rd_en, wr_en, tx_ready, rx_valid;
  logic [3:0]  be;
  logic [31:0] addr, wdata, rx_data;
  logic [31:0] rdata, tx_data;
  logic        tx_valid, rx_ready, irq;

  int n_tests = 0;
  int n_fail  = 0;
  int tx_seen = 0;

  // reference model state
  logic [31:0] tx_exp_q[$];
  logic [31:0] rx_q[$];
  logic [31:0] rd_exp_q[$];
  string       rd_nm_q[$];
  bit m_of, m_uf, irq_exp;
  bit rx_pop_now, rx_flush_now, tx_flush_now;

  dbus_stream_port #(.BASE_ADDR(32'hFF20_0100), .DEPTH(DEPTH)) dut (
    .iCLK(clk), .iRST(rst_n),
    .iDwReadEnable(rd_en), .iDwWriteEnable(wr_en), .iDwByteEnable(be),
    .iDwAddress(addr), .iDwWriteData(wdata), .oDwReadData(rdata),
    .oTxData(tx_data), .oTxValid(tx_valid), .iTxReady(tx_ready),
    .iRxData(rx_data), .iRxValid(rx_valid), .oRxReady(rx_ready),
    .oIRQ(irq)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    int tc, rc;
    tc = tx_exp_q.size();
    rc = rx_q.size();
    return {8'h00, 8'(rc), 8'(tc), 2'b00, m_uf, m_of,
            rc == 0, rc == int'(DEPTH), tc == 0, tc == int'(DEPTH)};
  endfunction

  // drivers: called just after a rising edge, they present one access
  task automatic start_read(input logic [31:0] a, input string nm);
    logic [31:0] e;
    e = '0;
    rd_en = 1'b1;
    addr  = a;
    if (a == A_DATA) begin
      if (rx_q.size() != 0) begin
        e = rx_q[0];
        rx_pop_now = 1'b1;
      end else begin
        m_uf = 1'b1;
      end
    end else if (a == A_STAT) begin
      e = exp_status();
    end
    rd_exp_q.push_back(e);
    rd_nm_q.push_back(nm);
  endtask

  task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    be    = b;
    if (a == A_DATA && b == 4'hF) begin
      if (tx_exp_q.size() >= DEPTH && !tx_ready) m_of = 1'b1;
      else tx_exp_q.push_back(d);
    end else if (a == A_CTRL) begin
      if (d[0]) tx_flush_now = 1'b1;
      if (d[1]) rx_flush_now = 1'b1;
      if (d[2]) begin
        m_of = 1'b0;
        m_uf = 1'b0;
      end
    end
  endtask

  task automatic bus_read(input logic [31:0] a, input int hold, input string nm);
    @(posedge clk); #1;
    start_read(a, nm);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    @(posedge clk); #1;
    start_write(a, d, b);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // monitor / scoreboard
  initial begin
    int rx_sz;
    bit rdy_exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        irq_exp = 1'b0;
      end else begin
        if (rd_exp_q.size() != 0) check(rd_nm_q.pop_front(), rdata, rd_exp_q.pop_front());
        check("irq", {31'b0, irq}, {31'b0, irq_exp});
        rx_sz   = rx_q.size();
        irq_exp = (rx_sz != 0);
        rdy_exp = (rx_sz < int'(DEPTH));
        if (rx_valid) check("rx_ready", {31'b0, rx_ready}, {31'b0, rdy_exp});
        if (rx_flush_now) begin
          rx_q.delete();
          rx_flush_now = 1'b0;
          rx_pop_now   = 1'b0;
        end else begin
          if (rx_pop_now) begin
            void'(rx_q.pop_front());
            rx_pop_now = 1'b0;
          end
          if (rx_valid && rdy_exp) rx_q.push_back(rx_data);
        end
        if (tx_valid && tx_ready) begin
          tx_seen++;
          if (tx_exp_q.size() == 0) check("tx_extra_word", tx_data, 32'hxxxx_xxxx);
          else check("tx_data", tx_data, tx_exp_q.pop_front());
        end
        if (tx_flush_now) begin
          tx_exp_q.delete();
          tx_flush_now = 1'b0;
        end
      end
    end
  end

  task automatic model_reset();
    tx_exp_q.delete();
    rx_q.delete();
    rd_exp_q.delete();
    rd_nm_q.delete();
    m_of = 1'b0; m_uf = 1'b0; irq_exp = 1'b0;
    rx_pop_now = 1'b0; rx_flush_now = 1'b0; tx_flush_now = 1'b0;
  endtask

  // stimulus
  initial begin
    int start_seen;
    logic [31:0] w;
    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; be = 4'h0;
    addr = '0; wdata = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    #1 check("post_rst_rx_ready", {31'b0, rx_ready}, 32'd1);

    // reset status, empty read, underflow
    bus_read(A_STAT, 1, "reset_status");
    bus_read(A_DATA, 1, "empty_data_read");
    bus_read(A_STAT, 1, "underflow_status");

    // TX fill past full with consumer stalled, then drain in order
    for (int k = 1; k <= int'(DEPTH) + 1; k++) bus_write(A_DATA, 32'h11 * k, 4'hF);
    bus_read(A_STAT, 1, "tx_full_status");
    start_seen = tx_seen;
    @(posedge clk); #1 tx_ready = 1'b1;
    for (int i = 0; i < int'(DEPTH) + 8 && tx_exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("tx_drain_count", tx_seen - start_seen, DEPTH);
    check("tx_drain_left", tx_exp_q.size(), 0);
    @(posedge clk); #1 tx_ready = 1'b0;

    // partial byte enable ignored
    bus_write(A_CTRL, 32'h4, 4'hF);
    bus_write(A_DATA, 32'hDEAD_BEEF, 4'b0011);
    bus_read(A_STAT, 1, "byte_enable_status");

    // held read pops once
    @(posedge clk); #1 rx_valid = 1'b1; rx_data = 32'hAAAA_0001;
    @(posedge clk); #1 rx_data = 32'hBBBB_0002;
    @(posedge clk); #1 rx_data = 32'hCCCC_0003;
    @(posedge clk); #1 rx_valid = 1'b0;
    bus_read(A_STAT, 1, "rx3_status");
    bus_read(A_DATA, 4, "held_read_first");
    bus_read(A_STAT, 1, "held_read_status");
    bus_read(A_DATA, 1, "fresh_read");

    // RX fill to DEPTH with a pop against a held producer
    bus_write(A_CTRL, 32'h2, 4'hF);
    @(posedge clk); #1 rx_valid = 1'b1; rx_data = $urandom;
    for (int i = 1; i < int'(DEPTH); i++) begin
      @(posedge clk); #1 rx_data = $urandom;
    end
    @(posedge clk); #1 rx_data = $urandom;
    start_read(A_DATA, "full_pop_read");
    @(posedge clk); #1 rd_en = 1'b0; rx_data = $urandom;
    @(posedge clk); #1 rx_valid = 1'b0;
    bus_read(A_STAT, 1, "rx_refill_status");

    // randomised traffic
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      tx_ready = ($urandom_range(0, 9) < 4);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = $urandom;
      case ($urandom_range(0, 6))
        0, 1: start_write(A_DATA, $urandom, 4'hF);
        2:    start_write(A_DATA, $urandom, 4'(($urandom_range(0, 14))));
        3, 4: start_read(A_DATA, "rnd_data");
        5:    start_read(A_STAT, "rnd_status");
        default: start_read(($urandom_range(0, 1) != 0) ? A_RSV : A_OTH, "rnd_other");
      endcase
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0; rx_data = $urandom;
    end
    @(posedge clk); #1 rx_valid = 1'b0; tx_ready = 1'b0;
    bus_read(A_CTRL, 1, "ctrl_reads_zero");

    // flush both with concurrent TX pop and RX push
    for (int k = 0; k < 3; k++) bus_write(A_DATA, $urandom, 4'hF);
    @(posedge clk); #1;
    tx_ready = 1'b1; rx_valid = 1'b1; rx_data = $urandom;
    start_write(A_CTRL, 32'h7, 4'hF);
    @(posedge clk); #1;
    wr_en = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    bus_read(A_STAT, 1, "flush_status");

    // reset mid-transfer
    bus_write(A_DATA, 32'h1234_5678, 4'hF);
    bus_write(A_DATA, 32'h9ABC_DEF0, 4'hF);
    @(posedge clk); #1 w = {31'b0, tx_valid};
    check("pre_rst_tx_valid", w, 32'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    model_reset();
    #1 check("mid_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("mid_rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    bus_read(A_STAT, 1, "post_rst_status");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pending_reads", rd_exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
